byte_stream_comparator: RTL and testbench
=========================================

BYTE_STREAM_COMPARATOR -- requirements
Module: byte_stream_comparator

Interface
REQ-001 The block SHALL have a parameter MAX_BYTES, default 4, setting the maximum bytes per comparison (legal range 1..16).
REQ-002 The block SHALL use one clock, clk; reset is asynchronous and active-high on port rst.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 start  input  1  begins a new comparison; sampled only in IDLE.
REQ-006 a_byte  input  8  operand A byte, most significant byte first.
REQ-007 b_byte  input  8  operand B byte, most significant byte first.
REQ-008 byte_valid  input  1  a_byte/b_byte are valid this cycle.
REQ-009 last  input  1  the current valid byte pair is the final (least significant) pair.
REQ-010 byte_ready  output  1  block accepts a byte pair this cycle (high only in RUN).
REQ-011 busy  output  1  high in RUN and DONE.
REQ-012 done  output  1  one-cycle pulse when the result is final.
REQ-013 eq_out  output  1  running/final A==B; drives the cascade eq input of the downstream 8-bit stage.
REQ-014 gt_out  output  1  running/final A>B; drives the cascade gt input of the downstream 8-bit stage.
REQ-015 overrun  output  1  MAX_BYTES pairs were accepted without last.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and DONE.
REQ-017 IDLE->RUN on start=1; the same edge SHALL set eq_out=1, gt_out=0, overrun=0 and byte count=0.
REQ-018 A byte pair SHALL be accepted on a rising edge where state=RUN and byte_valid=1; byte_valid outside RUN SHALL be ignored.
REQ-019 On acceptance with eq_out=1: eq_out<=(a_byte==b_byte) and gt_out<=(a_byte>b_byte); with eq_out=0 both SHALL hold (decision frozen), while bytes are still consumed.
REQ-020 The byte compare SHALL be unsigned, except the first accepted byte when the signed feature (REQ-030) is compiled in.
REQ-021 RUN->DONE on acceptance with last=1, or on acceptance of byte number MAX_BYTES with last=0, which SHALL also set overrun=1.
REQ-022 done SHALL be high for exactly the one cycle spent in DONE (latency: one cycle after the final accepting edge); DONE->IDLE unconditionally.
REQ-023 eq_out, gt_out and overrun SHALL hold their final values in IDLE until the next start.
REQ-024 start while in RUN or DONE SHALL be ignored; start together with byte_valid in IDLE SHALL not accept that byte.
REQ-025 eq_out=1 and gt_out=1 SHALL never be asserted together.
REQ-026 The byte counter SHALL saturate and never wrap within a comparison.

Reset
REQ-027 rst=1 SHALL immediately force state=IDLE, byte count=0, eq_out=1, gt_out=0, done=0, overrun=0, byte_ready=0 and busy=0, regardless of clk.
REQ-028 Reset during RUN SHALL abandon the comparison with no done pulse; the next comparison SHALL need a fresh start.

Configuration
REQ-029 The feature macro SHALL be BYTE_CMP_SIGNED_MSB_EN.
REQ-030 Defined: the first accepted byte SHALL be compared as two's complement (operand sign bit 7), and later bytes unsigned; undefined: all bytes SHALL be compared unsigned.

Verification
REQ-031 Bytes A=2E,2E,2E,2E and B=2E,2E,2E,2E (last on 4th) -> done one cycle after 4th accept; eq_out=1, gt_out=0, overrun=0.
REQ-032 A=12,34,FF and B=12,35,00 (last on 3rd) -> eq_out=0 and gt_out=0 after byte 2, held through byte 3 and in IDLE.
REQ-033 Single pair A=80, B=7F with last=1 -> macro defined: gt_out=0, eq_out=0; macro undefined: gt_out=1, eq_out=0.
REQ-034 Five pairs of 01 vs 01 with last never asserted, MAX_BYTES=4 -> DONE after 4th accept, overrun=1, eq_out=1; the 5th pair is not accepted.
REQ-035 rst pulsed mid-RUN after 2 bytes -> outputs at reset values immediately, no done pulse; a new start then runs normally.
REQ-036 start held high through RUN and DONE -> no restart until IDLE; byte_valid before start -> ignored, eq_out stays 1.

Source files
------------

// File: rtl/byte_stream_comparator.sv
// MSB-first serial comparator of two byte streams with cascade eq/gt outputs.
// Optional feature macro BYTE_CMP_SIGNED_MSB_EN: first accepted byte compared as two's complement.
module byte_stream_comparator #(
  parameter int MAX_BYTES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] a_byte,
  input  logic [7:0] b_byte,
  input  logic       byte_valid,
  input  logic       last,
  output logic       byte_ready,
  output logic       busy,
  output logic       done,
  output logic       eq_out,
  output logic       gt_out,
  output logic       overrun
);

  // state | meaning
  // IDLE  | waiting for start, previous result held
  // RUN   | accepting byte pairs, MSB first
  // DONE  | one-cycle result-final pulse
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CW = $clog2(MAX_BYTES + 1);

  state_t        r_state;
  logic [CW-1:0] r_count;
  logic          w_byte_eq;
  logic          w_byte_gt;
  logic          w_final_cnt;

  assign w_byte_eq   = (a_byte == b_byte);
  assign w_final_cnt = (r_count == CW'(MAX_BYTES - 1));

`ifdef BYTE_CMP_SIGNED_MSB_EN
  logic w_first;
  assign w_first   = (r_count == '0);
  assign w_byte_gt = w_first ? ($signed(a_byte) > $signed(b_byte)) : (a_byte > b_byte);
`else
  assign w_byte_gt = (a_byte > b_byte);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_count    <= '0;
      eq_out     <= 1'b1;
      gt_out     <= 1'b0;
      overrun    <= 1'b0;
      done       <= 1'b0;
      byte_ready <= 1'b0;
      busy       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state    <= RUN;
            r_count    <= '0;
            eq_out     <= 1'b1;
            gt_out     <= 1'b0;
            overrun    <= 1'b0;
            byte_ready <= 1'b1;
            busy       <= 1'b1;
          end
        end
        RUN: begin
          if (byte_valid) begin
            // once a difference is seen the decision is frozen
            if (eq_out) begin
              eq_out <= w_byte_eq;
              gt_out <= w_byte_gt;
            end
            if (r_count != CW'(MAX_BYTES)) r_count <= r_count + 1'b1;
            if (last || w_final_cnt) begin
              r_state    <= DONE;
              done       <= 1'b1;
              byte_ready <= 1'b0;
              overrun    <= ~last;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state    <= IDLE;
          byte_ready <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_byte_stream_comparator.sv
// Randomized and directed bench for byte_stream_comparator against a first-difference reference model.
module tb_byte_stream_comparator;
  localparam int MAX = 4;
`ifdef BYTE_CMP_SIGNED_MSB_EN
  localparam bit SIGNED_MSB = 1'b1;
`else
  localparam bit SIGNED_MSB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, start, byte_valid, last;
  logic [7:0] a_byte, b_byte;
  logic       byte_ready, busy, done, eq_out, gt_out, overrun;

  int n_checks = 0;
  int n_err    = 0;
  logic [7:0] ta [16];
  logic [7:0] tb [16];

  byte_stream_comparator #(.MAX_BYTES(MAX)) dut (
    .clk(clk), .rst(rst), .start(start), .a_byte(a_byte), .b_byte(b_byte),
    .byte_valid(byte_valid), .last(last), .byte_ready(byte_ready), .busy(busy),
    .done(done), .eq_out(eq_out), .gt_out(gt_out), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Result over the first k pairs: decided by the first differing pair, if any.
  function automatic logic [1:0] model(input int k);
    logic e, g;
    e = 1'b1;
    g = 1'b0;
    for (int i = 0; i < k; i++) begin
      if (e && ta[i] != tb[i]) begin
        e = 1'b0;
        if (i == 0 && SIGNED_MSB) g = ($signed(ta[i]) > $signed(tb[i]));
        else g = (ta[i] > tb[i]);
      end
    end
    return {e, g};
  endfunction

  task automatic run_cmp(input int n, input bit use_last, input bit gaps, input bit hold_start, input string name);
    int idx, acc_exp, cyc;
    bit ovr_exp, drove_final, finished;
    logic [1:0] exp;
    acc_exp = use_last ? ((n < MAX) ? n : MAX) : MAX;
    ovr_exp = !(use_last && n <= MAX);
    idx = 0; cyc = 0; drove_final = 0; finished = 0;
    @(negedge clk);
    start = 1'b1; byte_valid = 1'b1; a_byte = 8'hFF; b_byte = 8'h00; last = 1'b1;
    while (!finished && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (!hold_start) start = 1'b0;
      if (drove_final) begin
        exp = model(acc_exp);
        n_checks++;
        if (done !== 1'b1) begin n_err++; $display("FAIL %s done_pulse: got %b exp 1", name, done); end
        n_checks++;
        if ({eq_out, gt_out} !== exp) begin n_err++; $display("FAIL %s final_eq_gt: got %b%b exp %b", name, eq_out, gt_out, exp); end
        n_checks++;
        if (overrun !== ovr_exp) begin n_err++; $display("FAIL %s overrun: got %b exp %b", name, overrun, ovr_exp); end
        n_checks++;
        if (byte_ready !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL %s done_ready_busy: got %b%b exp 01", name, byte_ready, busy); end
        finished = 1;
        byte_valid = 1'b1;
        a_byte = (idx < n) ? ta[idx] : 8'($urandom);
        b_byte = (idx < n) ? tb[idx] : 8'($urandom);
        last = 1'($urandom);
      end else begin
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL %s run_done_busy: got %b%b exp 01 at byte %0d", name, done, busy, idx); end
        if (idx > 0) begin
          exp = model(idx);
          n_checks++;
          if ({eq_out, gt_out} !== exp) begin n_err++; $display("FAIL %s running_eq_gt: got %b%b exp %b after %0d bytes", name, eq_out, gt_out, exp, idx); end
        end
        if (byte_ready && idx < n && !(gaps && $urandom_range(0, 2) == 0)) begin
          a_byte = ta[idx]; b_byte = tb[idx]; byte_valid = 1'b1;
          last = use_last && (idx == n - 1);
          idx++;
          if (idx == acc_exp) drove_final = 1;
        end else begin
          byte_valid = 1'b0; a_byte = 8'($urandom); b_byte = 8'($urandom); last = 1'($urandom);
        end
      end
    end
    if (!finished) begin
      n_checks++; n_err++;
      $display("FAIL %s timeout: no done within 200 cycles, accepted %0d exp %0d", name, idx, acc_exp);
    end else begin
      @(negedge clk);
      start = 1'b0;
      exp = model(acc_exp);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || byte_ready !== 1'b0) begin
        n_err++; $display("FAIL %s idle_flags: got done=%b busy=%b ready=%b exp 000", name, done, busy, byte_ready);
      end
      n_checks++;
      if ({eq_out, gt_out, overrun} !== {exp, ovr_exp}) begin
        n_err++; $display("FAIL %s idle_hold: got %b%b%b exp %b%b", name, eq_out, gt_out, overrun, exp, ovr_exp);
      end
      @(negedge clk);
      n_checks++;
      if ({eq_out, gt_out, overrun, busy} !== {exp, ovr_exp, 1'b0}) begin
        n_err++; $display("FAIL %s idle_hold2: got %b%b%b%b exp %b%b0", name, eq_out, gt_out, overrun, busy, exp, ovr_exp);
      end
      byte_valid = 1'b0; last = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; last = 1'b0; a_byte = 8'h00; b_byte = 8'h00;
    #2;
    n_checks++;
    if ({byte_ready, busy, done, eq_out, gt_out, overrun} !== 6'b000100) begin
      n_err++; $display("FAIL reset_async: got %b exp 000100", {byte_ready, busy, done, eq_out, gt_out, overrun});
    end
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({byte_ready, busy, done, eq_out, gt_out, overrun} !== 6'b000100) begin
      n_err++; $display("FAIL reset_held: got %b exp 000100", {byte_ready, busy, done, eq_out, gt_out, overrun});
    end
  endtask

  task automatic test_valid_before_start();
    for (int i = 0; i < 3; i++) begin
      byte_valid = 1'b1; a_byte = 8'h01; b_byte = 8'h02; last = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({eq_out, gt_out, busy, done} !== 4'b1000) begin
        n_err++; $display("FAIL valid_before_start: got eq=%b gt=%b busy=%b done=%b exp 1000", eq_out, gt_out, busy, done);
      end
    end
    byte_valid = 1'b0; last = 1'b0;
  endtask

  task automatic test_directed();
    for (int i = 0; i < 4; i++) begin ta[i] = 8'h2E; tb[i] = 8'h2E; end
    run_cmp(4, 1, 0, 0, "all_equal");
    ta[0] = 8'h12; ta[1] = 8'h34; ta[2] = 8'hFF;
    tb[0] = 8'h12; tb[1] = 8'h35; tb[2] = 8'h00;
    run_cmp(3, 1, 0, 0, "frozen_lt");
    ta[0] = 8'h80; tb[0] = 8'h7F;
    run_cmp(1, 1, 0, 0, "msb_sign");
    for (int i = 0; i < 5; i++) begin ta[i] = 8'h01; tb[i] = 8'h01; end
    run_cmp(5, 0, 0, 0, "overrun");
  endtask

  task automatic test_mid_reset();
    ta[0] = 8'h05; tb[0] = 8'h03; ta[1] = 8'h00; tb[1] = 8'h00;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    a_byte = ta[0]; b_byte = tb[0]; byte_valid = 1'b1; last = 1'b0;
    @(negedge clk); a_byte = ta[1]; b_byte = tb[1];
    @(negedge clk); byte_valid = 1'b0;
    n_checks++;
    if ({eq_out, gt_out, busy} !== 3'b011) begin
      n_err++; $display("FAIL mid_reset_pre: got eq=%b gt=%b busy=%b exp 011", eq_out, gt_out, busy);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({byte_ready, busy, done, eq_out, gt_out, overrun} !== 6'b000100) begin
      n_err++; $display("FAIL mid_reset_async: got %b exp 000100", {byte_ready, busy, done, eq_out, gt_out, overrun});
    end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_err++; $display("FAIL mid_reset_no_done: got done=%b busy=%b exp 00", done, busy);
      end
    end
    ta[0] = 8'h40; tb[0] = 8'h40; ta[1] = 8'h41; tb[1] = 8'h40;
    run_cmp(2, 1, 0, 0, "after_reset");
  endtask

  task automatic test_hold_start();
    ta[0] = 8'h10; tb[0] = 8'h20; ta[1] = 8'h00; tb[1] = 8'h00; ta[2] = 8'h99; tb[2] = 8'h11;
    run_cmp(3, 1, 0, 1, "hold_start");
  endtask

  task automatic test_random();
    int n;
    bit ul;
    for (int t = 0; t < 25; t++) begin
      ul = 1'($urandom);
      n = ul ? int'($urandom_range(1, 6)) : MAX + int'($urandom_range(0, 2));
      for (int i = 0; i < 16; i++) begin
        ta[i] = 8'($urandom);
        tb[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : ta[i];
      end
      run_cmp(n, ul, 1, 0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_valid_before_start();
    test_directed();
    test_mid_reset();
    test_hold_start();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end

endmodule
